lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Memory-access stage directly downstream of the execute ALU.
- Takes the ALU's alucode and alu_result (the effective address for ALU_LB..ALU_SW) plus the store operand. Runs a request/grant/response transaction with data memory, then aligns and extends the load data.
- Non-memory alucodes pass alu_result through unchanged. Results go to writeback over a valid/ready handshake.

Parameters:
ADDR_WIDTH, 32, byte-address width of mem_addr; upper bits come from alu_result.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute result valid
in_ready  out  1  stage can accept (high only in IDLE)
in_alucode  in  6  ALU opcode (`ALU_* from define.vh)
in_result  in  32  ALU result / effective address
in_store_data  in  32  rs2 value for stores
in_rd  in  5  destination register tag
out_valid  out  1  writeback data valid
out_ready  in  1  writeback accepts
out_data  out  32  load data, passthrough result, 0 for stores, or faulting address
out_rd  out  5  captured in_rd
out_misalign  out  1  misaligned access flagged
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
mem_wstrb  out  4  byte write enables
mem_wdata  out  32  write data, lane-replicated
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0 except in_ready=1 (combinational from IDLE). An in-flight transaction is abandoned; mem_req drops immediately and any late rvalid/gnt is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, on in_valid&in_ready: capture alucode, address, store data, rd.
  - Non-memory alucode -> RESP with out_data=in_result.
  - Misaligned -> RESP with out_misalign=1, out_data=address, no memory request. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Otherwise -> REQ.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_wstrb, mem_wdata are registered and held stable until mem_gnt.
  - mem_gnt is legal in the first REQ cycle.
  - On gnt: store -> RESP (out_data=0); load -> WAIT. mem_req deasserts the cycle after gnt.
- Store lanes:
  - SB: wstrb=1<<addr[1:0], wdata={4{byte}}.
  - SH: wstrb=addr[1]?4'b1100:4'b0011, wdata={2{half}}.
  - SW: wstrb=4'b1111.
- Loads: mem_we=0, wstrb=0.
- WAIT, on mem_rvalid (earliest the cycle after gnt):
  - Select byte rdata[8*addr[1:0]+:8] or half rdata[16*addr[1]+:16].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
  - Register into out_data, then -> RESP.
- RESP:
  - out_valid=1; out_data, out_rd, out_misalign held stable until out_ready.
  - On out_valid&out_ready -> IDLE; out_valid clears next cycle.
  - No new input is accepted in the handshake cycle (in_ready=0 outside IDLE).
- Latency from acceptance edge:
  - Passthrough or misaligned: out_valid after 1 cycle.
  - Store with immediate gnt: 2 cycles.
  - Load with immediate gnt and rvalid the next cycle: 3 cycles.
  - Each gnt/rvalid stall cycle adds 1.
- Unexpected mem_rvalid in IDLE/REQ/RESP, or mem_gnt outside REQ: ignored.
- One outstanding transaction maximum. No throughput pipelining.

Test Plan:
- Passthrough: ALU_ADD, in_result=0x0000_1234, rd=5, out_ready=1 -> out_valid one cycle after accept, out_data=0x1234, out_rd=5, mem_req never asserted.
- Store byte: ALU_SB, addr=0x1003, store_data=0xAABBCCDD, gnt same cycle -> mem_addr=0x1000, wstrb=4'b1000, wdata=0xDDDDDDDD, mem_we=1, out_valid 2 cycles after accept, out_data=0.
- Signed/unsigned loads at addr=0x2002, rdata=0x80FF_1234, rvalid one cycle after gnt:
  - LH -> out_data=0xFFFF80FF.
  - LHU -> 0x000080FF.
  - LB at 0x2003 -> 0xFFFFFF80.
  - LBU at 0x2000 -> 0x00000034.
- Stalls: LW at 0x3000, gnt held off 3 cycles, rvalid 2 cycles after gnt, out_ready low 2 cycles -> mem_req/addr stable throughout, out_data=rdata held until out_ready, in_ready=0 until return to IDLE.
- Misalign: LW at 0x4002 and SH at 0x4001 -> no mem_req, out_misalign=1, out_data=faulting address, next accept clears out_misalign.
- Reset mid-op: rst_n low while in WAIT -> mem_req/out_valid=0 immediately, in_ready=1, subsequent rvalid ignored, next ADD passes through correctly.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: runs one request/grant/response transaction with data
// memory per accepted instruction, then aligns/extends load data for writeback.
module lsu_mem_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            in_alucode,
    input  logic [31:0]           in_result,
    input  logic [31:0]           in_store_data,
    input  logic [4:0]            in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [4:0]            out_rd,
    output logic                  out_misalign,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    localparam logic [5:0] ALU_LB  = 6'd20;
    localparam logic [5:0] ALU_LH  = 6'd21;
    localparam logic [5:0] ALU_LW  = 6'd22;
    localparam logic [5:0] ALU_LBU = 6'd23;
    localparam logic [5:0] ALU_LHU = 6'd24;
    localparam logic [5:0] ALU_SB  = 6'd25;
    localparam logic [5:0] ALU_SH  = 6'd26;
    localparam logic [5:0] ALU_SW  = 6'd27;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic [5:0] op_q;
    logic [1:0] off_q;
    logic       accept;
    logic       acc_mem;
    logic       acc_mis;

    function automatic logic is_load(input logic [5:0] op);
        return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
               (op == ALU_LBU) || (op == ALU_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
        if (op == ALU_LH || op == ALU_LHU || op == ALU_SH)
            return off[0];
        else if (op == ALU_LW || op == ALU_SW)
            return off != 2'b00;
        else
            return 1'b0;
    endfunction

    function automatic logic [3:0] store_strb(input logic [5:0] op, input logic [1:0] off);
        case (op)
            ALU_SB:  return 4'b0001 << off;
            ALU_SH:  return off[1] ? 4'b1100 : 4'b0011;
            ALU_SW:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [5:0] op, input logic [31:0] data);
        case (op)
            ALU_SB:  return {4{data[7:0]}};
            ALU_SH:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [5:0] op, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*off +: 8];
        h = rdata[16*off[1] +: 16];
        case (op)
            ALU_LB:  return {{24{b[7]}}, b};
            ALU_LBU: return {24'd0, b};
            ALU_LH:  return {{16{h[15]}}, h};
            ALU_LHU: return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);
    assign mem_req   = (state == REQ);
    assign accept    = in_valid && in_ready;
    assign acc_mem   = is_load(in_alucode) || is_store(in_alucode);
    assign acc_mis   = acc_mem && is_misaligned(in_alucode, in_result[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (acc_mem && !acc_mis) ? REQ : RESP;
            REQ:  if (mem_gnt) state_nxt = is_store(op_q) ? RESP : WAIT;
            WAIT: if (mem_rvalid) state_nxt = RESP;
            RESP: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Captured request fields and the result register feeding writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            off_q        <= '0;
            out_rd       <= '0;
            out_data     <= '0;
            out_misalign <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wstrb    <= '0;
            mem_wdata    <= '0;
        end else begin
            if (accept) begin
                op_q         <= in_alucode;
                off_q        <= in_result[1:0];
                out_rd       <= in_rd;
                out_misalign <= acc_mis;
                mem_addr     <= {in_result[ADDR_WIDTH-1:2], 2'b00};
                mem_we       <= is_store(in_alucode) && !acc_mis;
                mem_wstrb    <= acc_mis ? 4'b0000 : store_strb(in_alucode, in_result[1:0]);
                mem_wdata    <= store_lanes(in_alucode, in_store_data);
                if (!acc_mem || acc_mis)
                    out_data <= in_result;
            end
            if (state == REQ && mem_gnt && is_store(op_q))
                out_data <= '0;
            if (state == WAIT && mem_rvalid)
                out_data <= load_align(op_q, off_q, mem_rdata);
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: passthrough, store lanes, load extension,
// stalls, misalignment and mid-transaction reset.
module tb_lsu_mem_stage;

    localparam logic [5:0] ALU_ADD = 6'd1;
    localparam logic [5:0] ALU_LB  = 6'd20;
    localparam logic [5:0] ALU_LH  = 6'd21;
    localparam logic [5:0] ALU_LW  = 6'd22;
    localparam logic [5:0] ALU_LBU = 6'd23;
    localparam logic [5:0] ALU_LHU = 6'd24;
    localparam logic [5:0] ALU_SB  = 6'd25;
    localparam logic [5:0] ALU_SH  = 6'd26;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_alucode = '0;
    logic [31:0] in_result = '0;
    logic [31:0] in_store_data = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    lsu_mem_stage #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_alucode(in_alucode),
        .in_result(in_result), .in_store_data(in_store_data), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_misalign(out_misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [5:0] op, input logic [31:0] res,
                          input logic [31:0] sd, input logic [4:0] rd);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid      = 1'b1;
        in_alucode    = op;
        in_result     = res;
        in_store_data = sd;
        in_rd         = rd;
        step();
        in_valid = 1'b0;
    endtask

    task automatic complete();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("done_valid", {31'd0, out_valid}, 32'd0);
        check("done_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic simple_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                               input logic [31:0] rdata, input logic [31:0] exp);
        accept(op, addr, 32'd0, 5'd3);
        check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_strb"}, {28'd0, mem_wstrb}, 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        step();
        mem_rvalid = 1'b0;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, out_data, exp);
        complete();
    endtask

    initial begin
        // reset state
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // passthrough
        accept(ALU_ADD, 32'h0000_1234, 32'd0, 5'd5);
        check("pass_valid", {31'd0, out_valid}, 32'd1);
        check("pass_data", out_data, 32'h0000_1234);
        check("pass_rd", {27'd0, out_rd}, 32'd5);
        check("pass_req", {31'd0, mem_req}, 32'd0);
        check("pass_mis", {31'd0, out_misalign}, 32'd0);
        complete();

        // store byte with grant in the first request cycle
        mem_gnt = 1'b1;
        accept(ALU_SB, 32'h0000_1003, 32'hAABB_CCDD, 5'd0);
        check("sb_req", {31'd0, mem_req}, 32'd1);
        check("sb_addr", mem_addr, 32'h0000_1000);
        check("sb_strb", {28'd0, mem_wstrb}, 32'b1000);
        check("sb_wdata", mem_wdata, 32'hDDDD_DDDD);
        check("sb_we", {31'd0, mem_we}, 32'd1);
        check("sb_valid_early", {31'd0, out_valid}, 32'd0);
        step();
        mem_gnt = 1'b0;
        check("sb_valid", {31'd0, out_valid}, 32'd1);
        check("sb_data", out_data, 32'd0);
        check("sb_req_drop", {31'd0, mem_req}, 32'd0);
        complete();

        // store half on upper lanes
        mem_gnt = 1'b1;
        accept(ALU_SH, 32'h0000_1002, 32'h1122_3344, 5'd0);
        check("sh_strb", {28'd0, mem_wstrb}, 32'b1100);
        check("sh_wdata", mem_wdata, 32'h3344_3344);
        step();
        mem_gnt = 1'b0;
        complete();

        // loads with sign/zero extension
        simple_load("lh", ALU_LH, 32'h0000_2002, 32'h80FF_1234, 32'hFFFF_80FF);
        simple_load("lhu", ALU_LHU, 32'h0000_2002, 32'h80FF_1234, 32'h0000_80FF);
        simple_load("lb", ALU_LB, 32'h0000_2003, 32'h80FF_1234, 32'hFFFF_FF80);
        simple_load("lbu", ALU_LBU, 32'h0000_2000, 32'h80FF_1234, 32'h0000_0034);

        // stalled load word
        accept(ALU_LW, 32'h0000_3000, 32'd0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            check("st_req_hold", {31'd0, mem_req}, 32'd1);
            check("st_addr_hold", mem_addr, 32'h0000_3000);
            check("st_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        mem_gnt = 1'b1;
        check("st_req_gnt", {31'd0, mem_req}, 32'd1);
        step();
        mem_gnt = 1'b0;
        check("st_req_after", {31'd0, mem_req}, 32'd0);
        check("st_wait_valid", {31'd0, out_valid}, 32'd0);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("st_valid_hold", {31'd0, out_valid}, 32'd1);
            check("st_data_hold", out_data, 32'hCAFE_F00D);
            check("st_rd_hold", {27'd0, out_rd}, 32'd9);
            check("st_resp_ready", {31'd0, in_ready}, 32'd0);
            if (i < 2) step();
        end
        complete();

        // misaligned accesses
        accept(ALU_LW, 32'h0000_4002, 32'd0, 5'd1);
        check("mlw_req", {31'd0, mem_req}, 32'd0);
        check("mlw_valid", {31'd0, out_valid}, 32'd1);
        check("mlw_mis", {31'd0, out_misalign}, 32'd1);
        check("mlw_data", out_data, 32'h0000_4002);
        complete();
        accept(ALU_SH, 32'h0000_4001, 32'h5555_5555, 5'd2);
        check("msh_req", {31'd0, mem_req}, 32'd0);
        check("msh_mis", {31'd0, out_misalign}, 32'd1);
        check("msh_data", out_data, 32'h0000_4001);
        complete();
        accept(ALU_ADD, 32'h0000_0042, 32'd0, 5'd4);
        check("mclr_mis", {31'd0, out_misalign}, 32'd0);
        check("mclr_data", out_data, 32'h0000_0042);
        complete();

        // reset while waiting for read data
        accept(ALU_LW, 32'h0000_5000, 32'd0, 5'd6);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("rw_in_wait", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_req", {31'd0, mem_req}, 32'd0);
        check("rw_valid", {31'd0, out_valid}, 32'd0);
        check("rw_ready", {31'd0, in_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1357_9BDF;
        step();
        mem_rvalid = 1'b0;
        check("rw_late_valid", {31'd0, out_valid}, 32'd0);
        check("rw_late_ready", {31'd0, in_ready}, 32'd1);
        accept(ALU_ADD, 32'hDEAD_0001, 32'd0, 5'd7);
        check("rw_add_valid", {31'd0, out_valid}, 32'd1);
        check("rw_add_data", out_data, 32'hDEAD_0001);
        check("rw_add_rd", {27'd0, out_rd}, 32'd7);
        complete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
